cpu_trace_emitter: RTL and testbench

- Serializes one CPU retirement record per transaction into the ASCII trace text that the CPU trace checker parses.
- Output is one character per beat.
- Register-write record: `^<time>@<pc>: $<reg> <= <data>#`
- Memory-write record: `^<time>@<pc>: *<addr> <= <data>#`
- Sits between the CPU writeback/store monitor and the trace character sink.

---
 rtl/cpu_trace_emitter.sv | 205 ++++++++++++++++++++
 tb/tb_cpu_trace_emitter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_emitter.sv
// rtl/cpu_trace_emitter.sv - serializes one CPU retirement record into ASCII trace characters.
// Optional build macro TRACE_NEWLINE_EN appends a 0x0A character after the closing '#'.
module cpu_trace_emitter (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_type,
  input  logic [15:0] in_time,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_reg,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  output logic [7:0]  char_out,
  output logic        char_valid,
  input  logic        char_ready,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_CARET, S_TIME, S_AT, S_PC, S_COLON, S_SP1, S_TAG,
    S_OPND, S_SP2, S_LT, S_EQ, S_SP3, S_DATA, S_HASH, S_NL
  } state_t;

  state_t      state, state_next;
  logic [2:0]  nib_idx, nib_next;
  logic [1:0]  dig_idx, dig_next;

  logic        r_type;
  logic [15:0] r_time;
  logic [31:0] r_pc;
  logic [4:0]  r_reg;
  logic [31:0] r_addr;
  logic [31:0] r_data;

  logic [4:0]  reg_tens;
  logic [4:0]  reg_ones;
  logic [1:0]  time_first;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  function automatic logic [7:0] bcd_char(input logic [3:0] n);
    return (n > 4'd9) ? 8'h39 : (8'h30 + {4'h0, n});
  endfunction

  function automatic logic [3:0] nib32(input logic [31:0] w, input logic [2:0] i);
    return w[{i, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] nib16(input logic [15:0] w, input logic [1:0] i);
    return w[{i, 2'b00} +: 4];
  endfunction

  assign reg_tens = r_reg / 5'd10;
  assign reg_ones = r_reg % 5'd10;

  // Index of the most significant non-zero time digit; 0 when the time is all zeros.
  always_comb begin
    time_first = 2'd0;
    if (r_time[15:12] != 4'h0)     time_first = 2'd3;
    else if (r_time[11:8] != 4'h0) time_first = 2'd2;
    else if (r_time[7:4] != 4'h0)  time_first = 2'd1;
  end

  assign in_ready   = (state == S_IDLE);
  assign char_valid = (state != S_IDLE);
  assign busy       = (state != S_IDLE);

  always_comb begin
    state_next = state;
    nib_next   = nib_idx;
    dig_next   = dig_idx;
    char_out   = 8'h00;
    case (state)
      S_IDLE: begin
        if (in_valid) state_next = S_CARET;
      end
      S_CARET: begin
        char_out = 8'h5e;
        if (char_ready) begin
          state_next = S_TIME;
          dig_next   = time_first;
        end
      end
      S_TIME: begin
        char_out = bcd_char(nib16(r_time, dig_idx));
        if (char_ready) begin
          if (dig_idx == 2'd0) state_next = S_AT;
          else                 dig_next   = dig_idx - 2'd1;
        end
      end
      S_AT: begin
        char_out = 8'h40;
        if (char_ready) begin
          state_next = S_PC;
          nib_next   = 3'd7;
        end
      end
      S_PC: begin
        char_out = hex_char(nib32(r_pc, nib_idx));
        if (char_ready) begin
          if (nib_idx == 3'd0) state_next = S_COLON;
          else                 nib_next   = nib_idx - 3'd1;
        end
      end
      S_COLON: begin
        char_out = 8'h3a;
        if (char_ready) state_next = S_SP1;
      end
      S_SP1: begin
        char_out = 8'h20;
        if (char_ready) state_next = S_TAG;
      end
      S_TAG: begin
        char_out = r_type ? 8'h2a : 8'h24;
        if (char_ready) begin
          state_next = S_OPND;
          // Register operand uses index 1 for the tens digit, 0 for the ones digit.
          nib_next   = r_type ? 3'd7 : ((r_reg >= 5'd10) ? 3'd1 : 3'd0);
        end
      end
      S_OPND: begin
        if (r_type)              char_out = hex_char(nib32(r_addr, nib_idx));
        else if (nib_idx[0])     char_out = 8'h30 + {3'b000, reg_tens};
        else                     char_out = 8'h30 + {3'b000, reg_ones};
        if (char_ready) begin
          if (nib_idx == 3'd0) state_next = S_SP2;
          else                 nib_next   = nib_idx - 3'd1;
        end
      end
      S_SP2: begin
        char_out = 8'h20;
        if (char_ready) state_next = S_LT;
      end
      S_LT: begin
        char_out = 8'h3c;
        if (char_ready) state_next = S_EQ;
      end
      S_EQ: begin
        char_out = 8'h3d;
        if (char_ready) state_next = S_SP3;
      end
      S_SP3: begin
        char_out = 8'h20;
        if (char_ready) begin
          state_next = S_DATA;
          nib_next   = 3'd7;
        end
      end
      S_DATA: begin
        char_out = hex_char(nib32(r_data, nib_idx));
        if (char_ready) begin
          if (nib_idx == 3'd0) state_next = S_HASH;
          else                 nib_next   = nib_idx - 3'd1;
        end
      end
      S_HASH: begin
        char_out = 8'h23;
`ifdef TRACE_NEWLINE_EN
        if (char_ready) state_next = S_NL;
`else
        if (char_ready) state_next = S_IDLE;
`endif
      end
      S_NL: begin
`ifdef TRACE_NEWLINE_EN
        char_out = 8'h0a;
        if (char_ready) state_next = S_IDLE;
`else
        state_next = S_IDLE;
`endif
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      nib_idx <= 3'd0;
      dig_idx <= 2'd0;
      r_type  <= 1'b0;
      r_time  <= 16'h0000;
      r_pc    <= 32'h0;
      r_reg   <= 5'd0;
      r_addr  <= 32'h0;
      r_data  <= 32'h0;
    end else begin
      state   <= state_next;
      nib_idx <= nib_next;
      dig_idx <= dig_next;
      if (state == S_IDLE && in_valid) begin
        r_type <= in_type;
        r_time <= in_time;
        r_pc   <= in_pc;
        r_reg  <= in_reg;
        r_addr <= in_addr;
        r_data <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// tb/tb_cpu_trace_emitter.sv - directed self-checking bench for cpu_trace_emitter.
module tb_cpu_trace_emitter;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_type;
  logic [15:0] in_time;
  logic [31:0] in_pc;
  logic [4:0]  in_reg;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [7:0]  char_out;
  logic        char_valid;
  logic        char_ready;
  logic        busy;

  int assertions;
  int failures;

`ifdef TRACE_NEWLINE_EN
  string      nl = "\n";
  logic [7:0] end_char = 8'h0a;
`else
  string      nl = "";
  logic [7:0] end_char = 8'h23;
`endif

  cpu_trace_emitter dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_type    (in_type),
    .in_time    (in_time),
    .in_pc      (in_pc),
    .in_reg     (in_reg),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .char_out   (char_out),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic start_record(input logic t, input logic [15:0] tm, input logic [31:0] pc,
                              input logic [4:0] rg, input logic [31:0] ad, input logic [31:0] dt,
                              input bit keep);
    int n;
    @(negedge clk);
    in_type = t; in_time = tm; in_pc = pc; in_reg = rg; in_addr = ad; in_data = dt;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    assertions++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    if (!keep) begin
      in_valid = 1'b0;
      in_type = ~t; in_time = 16'h8888; in_pc = ~pc; in_reg = ~rg; in_addr = ~ad; in_data = ~dt;
    end
    assertions++;
    if (char_valid !== 1'b1 || char_out !== 8'h5e || busy !== 1'b1) begin
      failures++;
      $display("FAIL first_char_latency: valid=%b char=%h busy=%b required valid=1 char=5e busy=1",
               char_valid, char_out, busy);
    end
  endtask

  task automatic collect(input bit bp, output string s);
    int n;
    bit held;
    bit done;
    bit cr;
    logic [7:0] prev;
    s = ""; held = 0; done = 0; n = 0; prev = 8'h00;
    while (!done && n < 400) begin
      assertions++;
      if (char_valid !== 1'b1) begin
        failures++;
        $display("FAIL char_bubble: char_valid=%b required 1 after %0d chars", char_valid, s.len());
        break;
      end
      if (held) begin
        assertions++;
        if (char_out !== prev) begin
          failures++;
          $display("FAIL hold_stable: char=%h required %h", char_out, prev);
        end
      end
      cr = bp ? ($urandom_range(0, 2) == 0 ? 1'b0 : ($urandom_range(0, 1) == 1)) : 1'b1;
      char_ready = cr;
      if (cr) begin
        s = $sformatf("%s%c", s, char_out);
        if (char_out == end_char) done = 1;
      end
      held = !cr;
      prev = char_out;
      @(negedge clk);
      n++;
    end
    char_ready = 1'b1;
    assertions++;
    if (!done) begin
      failures++;
      $display("FAIL record_end_timeout: got %0d chars, no end char", s.len());
    end
  endtask

  task automatic check_str(input string name, input string got, input string exp);
    assertions++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got \"%s\" required \"%s\"", name, got, exp);
    end
    assertions++;
    if (got.len() != exp.len()) begin
      failures++;
      $display("FAIL %s_len: got %0d required %0d", name, got.len(), exp.len());
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #1;
    assertions++;
    if (in_ready !== 1'b1 || char_valid !== 1'b0 || char_out !== 8'h00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: ready=%b valid=%b char=%h busy=%b required 1 0 00 0",
               in_ready, char_valid, char_out, busy);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    assertions++;
    if (in_ready !== 1'b1 || char_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: ready=%b valid=%b busy=%b required 1 0 0",
               in_ready, char_valid, busy);
    end
  endtask

  task automatic test_reg_record;
    string s;
    start_record(1'b0, 16'h0012, 32'h00003000, 5'd5, 32'h0, 32'h0000abcd, 1'b0);
    collect(1'b0, s);
    check_str("reg_record", s, {"^12@00003000: $5 <= 0000abcd#", nl});
    assertions++;
    if (in_ready !== 1'b1 || char_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reg_record_idle: ready=%b valid=%b busy=%b required 1 0 0",
               in_ready, char_valid, busy);
    end
  endtask

  task automatic test_mem_record;
    string s;
    start_record(1'b1, 16'h0000, 32'hdeadbeef, 5'd0, 32'h00000010, 32'hffffffff, 1'b0);
    collect(1'b0, s);
    check_str("mem_zero_time", s, {"^0@deadbeef: *00000010 <= ffffffff#", nl});
  endtask

  task automatic test_full_time;
    string s;
    start_record(1'b0, 16'h9999, 32'h00000004, 5'd31, 32'h0, 32'h12345678, 1'b0);
    collect(1'b0, s);
    check_str("reg31_time9999", s, {"^9999@00000004: $31 <= 12345678#", nl});
  endtask

  task automatic test_backpressure;
    string s;
    start_record(1'b0, 16'h0012, 32'h00003000, 5'd5, 32'h0, 32'h0000abcd, 1'b0);
    collect(1'b1, s);
    check_str("bp_reg_record", s, {"^12@00003000: $5 <= 0000abcd#", nl});
    start_record(1'b0, 16'h0a05, 32'hcafef00d, 5'd10, 32'h0, 32'h00000000, 1'b0);
    collect(1'b1, s);
    check_str("bp_nibble_gt9_reg10", s, {"^905@cafef00d: $10 <= 00000000#", nl});
  endtask

  task automatic test_reset_mid;
    string s;
    start_record(1'b0, 16'h0012, 32'h12345678, 5'd7, 32'h0, 32'h00000001, 1'b0);
    char_ready = 1'b1;
    repeat (8) @(negedge clk);
    assertions++;
    if (char_out !== 8'h35 || char_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_position: char=%h valid=%b required 35 1", char_out, char_valid);
    end
    #2 reset = 1'b0;
    #1;
    assertions++;
    if (char_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_async: valid=%b ready=%b busy=%b required 0 1 0",
               char_valid, in_ready, busy);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    assertions++;
    if (char_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_discard: char_valid=%b required 0", char_valid);
    end
    start_record(1'b1, 16'h0100, 32'h00000020, 5'd0, 32'hffff0000, 32'h89abcdef, 1'b0);
    collect(1'b0, s);
    check_str("after_reset_record", s, {"^100@00000020: *ffff0000 <= 89abcdef#", nl});
  endtask

  task automatic test_back_to_back;
    string s;
    start_record(1'b0, 16'h0012, 32'h00003000, 5'd5, 32'h0, 32'h0000abcd, 1'b1);
    collect(1'b0, s);
    check_str("b2b_first", s, {"^12@00003000: $5 <= 0000abcd#", nl});
    assertions++;
    if (char_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_gap: valid=%b ready=%b required 0 1", char_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    assertions++;
    if (char_valid !== 1'b1 || char_out !== 8'h5e) begin
      failures++;
      $display("FAIL b2b_second_start: valid=%b char=%h required 1 5e", char_valid, char_out);
    end
    collect(1'b0, s);
    check_str("b2b_second", s, {"^12@00003000: $5 <= 0000abcd#", nl});
  endtask

  initial begin
    assertions = 0;
    failures   = 0;
    reset      = 1'b0;
    in_valid   = 1'b0;
    in_type    = 1'b0;
    in_time    = 16'h0;
    in_pc      = 32'h0;
    in_reg     = 5'd0;
    in_addr    = 32'h0;
    in_data    = 32'h0;
    char_ready = 1'b1;
    test_reset();
    test_reg_record();
    test_mem_record();
    test_full_time();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
